// File: rtl/spi_xip_sched.sv
// Arbitrates an XIP flash-read port and a CPU register port onto the SPI master's
// Wishbone slave, expanding each XIP read into the full 0x03 read-command sequence.
module spi_xip_sched #(
    parameter logic [31:0] DIVIDER_VAL = 32'h1,
    parameter logic [7:0]  SS_MASK     = 8'h01,
    parameter logic [15:0] POLL_LIMIT  = 16'd1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        xip_req_valid,
    output logic        xip_req_ready,
    input  logic [23:0] xip_addr,
    output logic        xip_rsp_valid,
    output logic [31:0] xip_rsp_data,
    output logic        xip_rsp_err,
    input  logic        reg_valid,
    input  logic [4:0]  reg_addr,
    input  logic        reg_we,
    input  logic [31:0] reg_wdata,
    input  logic [3:0]  reg_sel,
    output logic        reg_ack,
    output logic [31:0] reg_rdata,
    output logic        reg_err,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_REG, S_TX1, S_TX0, S_DIV, S_SS, S_CTRL, S_POLL, S_RX0, S_SSCLR, S_RESP
    } state_t;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

    localparam logic [31:0] CTRL_GO = 32'h0000_2540;

    state_t      state;
    state_t      next_st;
    logic        recov;     // high during the idle cycle that follows every ack/err
    logic        last_xip;
    logic [23:0] addr_q;
    logic [15:0] poll_cnt;
    logic        err_q;
    logic [31:0] rx_q;

    function automatic wb_req_t xip_access(input state_t st, input logic [23:0] a);
        wb_req_t r;
        r = '{adr: 5'h00, dat: 32'h0, sel: 4'hF, we: 1'b1};
        case (st)
            S_TX1:   begin r.adr = 5'h04; r.dat = {8'h03, a}; end
            S_TX0:   r.adr = 5'h00;
            S_DIV:   begin r.adr = 5'h14; r.dat = DIVIDER_VAL; end
            S_SS:    begin r.adr = 5'h18; r.dat = {24'h0, SS_MASK}; end
            S_CTRL:  begin r.adr = 5'h10; r.dat = CTRL_GO; end
            S_POLL:  begin r.adr = 5'h10; r.sel = 4'h0; r.we = 1'b0; end
            S_RX0:   begin r.adr = 5'h00; r.we = 1'b0; end
            S_SSCLR: r.adr = 5'h18;
            default: r.we = 1'b0;
        endcase
        return r;
    endfunction

    // Flash returns the first byte in rx[31:24]; the XIP word is little-endian.
    function automatic logic [31:0] byte_swap(input logic [31:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

    // NOTE: all state and outputs live in this one clocked block and use <=, so every
    // read of a register sees its pre-edge value regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            next_st       <= S_IDLE;
            recov         <= 1'b0;
            last_xip      <= 1'b0;
            addr_q        <= '0;
            poll_cnt      <= '0;
            err_q         <= 1'b0;
            rx_q          <= '0;
            xip_req_ready <= 1'b0;
            xip_rsp_valid <= 1'b0;
            xip_rsp_data  <= '0;
            xip_rsp_err   <= 1'b0;
            reg_ack       <= 1'b0;
            reg_rdata     <= '0;
            reg_err       <= 1'b0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            wb_sel_o      <= '0;
            wb_we_o       <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_cyc_o      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            xip_req_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xip_req_valid && (!reg_valid || !last_xip)) begin
                        state         <= S_TX1;
                        last_xip      <= 1'b1;
                        addr_q        <= xip_addr;
                        poll_cnt      <= '0;
                        err_q         <= 1'b0;
                        rx_q          <= '0;
                        xip_req_ready <= 1'b1;
                        busy          <= 1'b1;
                        {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} <= xip_access(S_TX1, xip_addr);
                        wb_stb_o      <= 1'b1;
                        wb_cyc_o      <= 1'b1;
                    end else if (reg_valid) begin
                        state    <= S_REG;
                        last_xip <= 1'b0;
                        busy     <= 1'b1;
                        wb_adr_o <= reg_addr;
                        wb_dat_o <= reg_wdata;
                        wb_sel_o <= reg_sel;
                        wb_we_o  <= reg_we;
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                    end
                end
                S_RESP: begin
                    xip_rsp_valid <= 1'b0;
                    xip_rsp_data  <= '0;
                    xip_rsp_err   <= 1'b0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
                default: begin
                    if (recov) begin
                        recov <= 1'b0;
                        if (state == S_REG) begin
                            reg_ack <= 1'b0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else if (next_st == S_RESP) begin
                            state         <= S_RESP;
                            xip_rsp_valid <= 1'b1;
                            xip_rsp_data  <= err_q ? 32'h0 : byte_swap(rx_q);
                            xip_rsp_err   <= err_q;
                        end else begin
                            state    <= next_st;
                            {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} <= xip_access(next_st, addr_q);
                            wb_stb_o <= 1'b1;
                            wb_cyc_o <= 1'b1;
                        end
                    end else if (wb_ack_i || wb_err_i) begin
                        recov    <= 1'b1;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        if (state == S_REG) begin
                            reg_ack   <= 1'b1;
                            reg_rdata <= wb_dat_i;
                            reg_err   <= wb_err_i;
                        end else if (wb_err_i) begin
                            // SS must always be released, so errors divert to W_SSCLR.
                            err_q   <= 1'b1;
                            next_st <= (state == S_SSCLR) ? S_RESP : S_SSCLR;
                        end else begin
                            case (state)
                                S_TX1:  next_st <= S_TX0;
                                S_TX0:  next_st <= S_DIV;
                                S_DIV:  next_st <= S_SS;
                                S_SS:   next_st <= S_CTRL;
                                S_CTRL: next_st <= S_POLL;
                                S_POLL: begin
                                    if (!wb_dat_i[8]) begin
                                        next_st <= S_RX0;
                                    end else if (poll_cnt + 16'd1 == POLL_LIMIT) begin
                                        err_q   <= 1'b1;
                                        next_st <= S_SSCLR;
                                    end else begin
                                        poll_cnt <= poll_cnt + 16'd1;
                                        next_st  <= S_POLL;
                                    end
                                end
                                S_RX0: begin
                                    rx_q    <= wb_dat_i;
                                    next_st <= S_SSCLR;
                                end
                                default: next_st <= S_RESP;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xip_sched.sv
// Directed bench for spi_xip_sched with a behavioural SPI-master Wishbone slave that
// logs every access, models the CTRL GO bit and can inject one wb_err_i.
module tb_spi_xip_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        xip_req_valid = 1'b0;
    logic        xip_req_ready;
    logic [23:0] xip_addr = '0;
    logic        xip_rsp_valid;
    logic [31:0] xip_rsp_data;
    logic        xip_rsp_err;
    logic        reg_valid = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic        reg_we = 1'b0;
    logic [31:0] reg_wdata = '0;
    logic [3:0]  reg_sel = '0;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        reg_err;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Slave model state
    logic [31:0] regs [8];
    logic [41:0] log_q [$];
    logic [31:0] rx_word = '0;
    int unsigned go_polls = 0;
    int unsigned poll_seen = 0;
    int          npolls = 0;
    logic        err_arm = 1'b0;
    logic [4:0]  err_adr = '0;
    int          ack_cyc = 0;

    spi_xip_sched dut (
        .clock(clock), .reset(reset),
        .xip_req_valid(xip_req_valid), .xip_req_ready(xip_req_ready), .xip_addr(xip_addr),
        .xip_rsp_valid(xip_rsp_valid), .xip_rsp_data(xip_rsp_data), .xip_rsp_err(xip_rsp_err),
        .reg_valid(reg_valid), .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .reg_sel(reg_sel), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [41:0] ent(input logic we, input logic [3:0] sel,
                                        input logic [4:0] adr, input logic [31:0] dat);
        return {we, sel, adr, dat};
    endfunction

    // Zero-wait slave: answers on the first negedge that sees a new strobe.
    always @(negedge clock) begin
        if (wb_stb_o && wb_cyc_o && !wb_ack_i && !wb_err_i) begin
            log_q.push_back(ent(wb_we_o, wb_sel_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0));
            ack_cyc = cyc;
            wb_dat_i = 32'h0;
            if (err_arm && wb_adr_o == err_adr) begin
                err_arm  = 1'b0;
                wb_err_i = 1'b1;
            end else begin
                wb_ack_i = 1'b1;
                if (wb_we_o) begin
                    regs[wb_adr_o[4:2]] = wb_dat_o;
                    if (wb_adr_o == 5'h10) poll_seen = 0;
                end else if (wb_adr_o == 5'h10) begin
                    wb_dat_i = (poll_seen < go_polls) ? 32'h0000_2540 : 32'h0000_2440;
                    poll_seen++;
                    npolls++;
                end else if (wb_adr_o == 5'h00) begin
                    wb_dat_i = rx_word;
                end else begin
                    wb_dat_i = regs[wb_adr_o[4:2]];
                end
            end
        end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xip_read(input logic [23:0] a, output logic [31:0] d, output logic e);
        int n;
        @(negedge clock);
        xip_addr = a;
        xip_req_valid = 1'b1;
        n = 0;
        while (!xip_req_ready && n < 50) begin @(negedge clock); n++; end
        xip_req_valid = 1'b0;
        check("xip_ready_seen", xip_req_ready, 1);
        n = 0;
        while (!xip_rsp_valid && n < 6000) begin @(negedge clock); n++; end
        check("xip_rsp_seen", xip_rsp_valid, 1);
        d = xip_rsp_data;
        e = xip_rsp_err;
        @(negedge clock);
        check("xip_rsp_one_cycle", xip_rsp_valid, 0);
    endtask

    task automatic reg_access(input logic [4:0] a, input logic we, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er, output int gap,
                              output logic busy_after);
        int n;
        @(negedge clock);
        reg_addr = a; reg_we = we; reg_wdata = wd; reg_sel = 4'hF; reg_valid = 1'b1;
        n = 0;
        while (!reg_ack && n < 50) begin @(negedge clock); n++; end
        check("reg_ack_seen", reg_ack, 1);
        rd = reg_rdata;
        er = reg_err;
        gap = cyc - ack_cyc;
        reg_valid = 1'b0;
        @(negedge clock);
        busy_after = busy;
    endtask

    task automatic both_req(output int rdy_c, output int rsp_c, output int ack_c);
        int n;
        rdy_c = -1; rsp_c = -1; ack_c = -1;
        @(negedge clock);
        xip_addr = 24'h000300; xip_req_valid = 1'b1;
        reg_addr = 5'h1C; reg_we = 1'b1; reg_wdata = 32'h77; reg_sel = 4'hF; reg_valid = 1'b1;
        n = 0;
        while ((rsp_c < 0 || ack_c < 0) && n < 6000) begin
            @(negedge clock);
            n++;
            if (xip_req_ready) begin rdy_c = cyc; xip_req_valid = 1'b0; end
            if (xip_rsp_valid) rsp_c = cyc;
            if (reg_ack) begin ack_c = cyc; reg_valid = 1'b0; end
        end
        xip_req_valid = 1'b0;
        reg_valid = 1'b0;
        check("both_done", (rsp_c >= 0) && (ack_c >= 0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] rd;
        logic        er;
        logic        ba;
        int          gap;
        int          rdy_c, rsp_c, ack_c;
        int          n;
        int          seen;
        logic [41:0] exp_tab [10];

        for (int i = 0; i < 8; i++) regs[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ctl", {wb_stb_o, wb_cyc_o, wb_we_o, busy, xip_req_ready, xip_rsp_valid, reg_ack}, 0);
        check("rst_data", {wb_adr_o, wb_dat_o, wb_sel_o, xip_rsp_data, reg_rdata}, 0);
        reset = 1'b1;

        // Normal XIP read: two busy polls then GO clears
        go_polls = 2; rx_word = 32'h1122_3344; npolls = 0; log_q.delete();
        xip_read(24'h000100, d, e);
        check("xip_data", d, 32'h4433_2211);
        check("xip_err", e, 0);
        check("xip_npolls", npolls, 3);
        exp_tab[0] = ent(1'b1, 4'hF, 5'h04, 32'h0300_0100);
        exp_tab[1] = ent(1'b1, 4'hF, 5'h00, 32'h0);
        exp_tab[2] = ent(1'b1, 4'hF, 5'h14, 32'h1);
        exp_tab[3] = ent(1'b1, 4'hF, 5'h18, 32'h1);
        exp_tab[4] = ent(1'b1, 4'hF, 5'h10, 32'h2540);
        exp_tab[5] = ent(1'b0, 4'h0, 5'h10, 32'h0);
        exp_tab[6] = ent(1'b0, 4'h0, 5'h10, 32'h0);
        exp_tab[7] = ent(1'b0, 4'h0, 5'h10, 32'h0);
        exp_tab[8] = ent(1'b0, 4'hF, 5'h00, 32'h0);
        exp_tab[9] = ent(1'b1, 4'hF, 5'h18, 32'h0);
        check("xip_seq_len", log_q.size(), 10);
        n = (log_q.size() < 10) ? log_q.size() : 10;
        for (int i = 0; i < n; i++) check($sformatf("xip_seq[%0d]", i), log_q[i], exp_tab[i]);

        // CPU register write then readback
        log_q.delete();
        reg_access(5'h14, 1'b1, 32'h5, rd, er, gap, ba);
        check("regw_gap", gap, 1);
        check("regw_busy_after", ba, 0);
        check("regw_err", er, 0);
        check("regw_log_len", log_q.size(), 1);
        if (log_q.size() > 0) check("regw_log", log_q[0], ent(1'b1, 4'hF, 5'h14, 32'h5));
        reg_access(5'h14, 1'b0, 32'h0, rd, er, gap, ba);
        check("regr_data", rd, 32'h5);

        // Both valid, last grant REG: XIP must go first, REG after its response
        go_polls = 0; rx_word = 32'h0;
        both_req(rdy_c, rsp_c, ack_c);
        check("rr1_xip_first", rdy_c < ack_c, 1);
        check("rr1_no_interleave", rsp_c < ack_c, 1);

        // Plain XIP leaves last grant XIP; both valid again must serve REG first
        rx_word = 32'hDEAD_BEEF;
        xip_read(24'h000010, d, e);
        check("xip2_data", d, 32'hEFBE_ADDE);
        both_req(rdy_c, rsp_c, ack_c);
        check("rr2_reg_first", ack_c < rdy_c, 1);

        // GO never clears: exactly POLL_LIMIT polls then timeout
        go_polls = 32'hFFFF_FFFF; npolls = 0; log_q.delete();
        xip_read(24'h000400, d, e);
        check("to_err", e, 1);
        check("to_data", d, 0);
        check("to_npolls", npolls, 1024);
        check("to_ssclr", log_q[$], ent(1'b1, 4'hF, 5'h18, 32'h0));

        // Bus error on the DIVIDER write skips straight to SS release
        go_polls = 0; err_arm = 1'b1; err_adr = 5'h14; log_q.delete();
        xip_read(24'h000500, d, e);
        check("werr_err", e, 1);
        check("werr_data", d, 0);
        check("werr_len", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("werr_div", log_q[2], ent(1'b1, 4'hF, 5'h14, 32'h1));
            check("werr_ssclr", log_q[3], ent(1'b1, 4'hF, 5'h18, 32'h0));
        end

        // Asynchronous reset while polling
        go_polls = 32'hFFFF_FFFF; npolls = 0;
        @(negedge clock);
        xip_addr = 24'h000600; xip_req_valid = 1'b1;
        n = 0;
        while (!xip_req_ready && n < 50) begin @(negedge clock); n++; end
        xip_req_valid = 1'b0;
        n = 0;
        while (npolls < 3 && n < 200) begin @(negedge clock); n++; end
        check("rst_mid_polling", npolls >= 3, 1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_ctl", {wb_stb_o, wb_cyc_o, busy, xip_rsp_valid}, 0);
        check("rst_mid_bus", {wb_adr_o, wb_dat_o, wb_we_o}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (xip_rsp_valid || busy) seen++;
        end
        check("rst_no_rsp", seen, 0);

        go_polls = 1; rx_word = 32'hA1B2_C3D4; log_q.delete();
        xip_read(24'h000200, d, e);
        check("post_rst_data", d, 32'hD4C3_B2A1);
        check("post_rst_err", e, 0);
        if (log_q.size() > 0) check("post_rst_tx1", log_q[0], ent(1'b1, 4'hF, 5'h04, 32'h0300_0200));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
